tdm_demux16: RTL
================

# tdm_demux16

Serial-to-parallel time-division demultiplexer: the receive-side counterpart of the 16:1 gate-level multiplexer tree. One bit arrives per valid cycle and is steered into one of 16 lane slots by a 4-bit slot counter. When slot 15 has been written, the full 16-lane word is presented in one cycle. A sync marker aligns slot 0 and enforces framing.

## Interface

Parameters:

- SYNC_REQUIRED, 1, when 1 the block starts in HUNT after reset and discards data until the first sync; when 0 it starts in LOCKED at slot 0.

Ports:

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. All state clears immediately on assertion; release is synchronous to clk.
- din  input  1  serial data bit.
- din_valid  input  1  din is accepted on this cycle.
- sync  input  1  marks the accompanied din as slot 0; only meaningful when din_valid=1.
- dout  output  [0:15]  registered parallel word; dout[k] is the bit received in slot k.
- dout_valid  output  1  one-cycle pulse when dout updates.
- slot  output  [0:3]  current slot counter; slot[0] is the MSB.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse when sync arrives mid-frame.

## Operation

- States: HUNT and LOCKED.
- Reset values: state = HUNT if SYNC_REQUIRED=1, else LOCKED. slot=0, dout=16'h0000, dout_valid=0, sync_err=0. The shadow register clears to 0.
- HUNT:
  - din_valid=1 with sync=1 → write shadow[0]=din, set slot=1, go to LOCKED.
  - din_valid=1 with sync=0 → bit discarded; slot stays 0.
- LOCKED, on each din_valid=1:
  - sync=0, slot<15 → shadow[slot]=din, slot=slot+1.
  - sync=0, slot=15 → dout={shadow[0:14],din}, dout_valid=1, slot wraps to 0.
  - sync=1, slot=0 → normal frame start: shadow[0]=din, slot=1, no error.
  - sync=1, slot≠0 → sync_err=1. The partial frame is discarded and dout is unchanged. Then shadow[0]=din, slot=1, and the block remains LOCKED.
- din_valid=0 → no state change. sync is ignored. The slot holds, so gaps in the stream are allowed anywhere in a frame.
- Shadow contents from a discarded partial frame are never emitted; every slot is overwritten before the next dout update.
- The block never returns to HUNT except through reset.

## Timing

- dout, dout_valid and sync_err are registered. They update on the clk edge that accepts the triggering bit and are visible in the following cycle.
- Latency: the slot-15 bit is accepted at edge N; dout and dout_valid are high in cycle N+1; dout_valid drops at N+2 unless another frame completes.
- Minimum frame period is 16 cycles, so back-to-back dout_valid pulses are spaced ≥16 cycles apart.
- slot reflects the slot the next accepted bit will occupy.
- dout holds its last value between pulses.
- Simultaneous sync and slot=15 (sync_err case): sync_err=1, dout_valid=0, dout unchanged.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously and the partial frame is lost. After release with SYNC_REQUIRED=1, the block waits in HUNT.

## Test plan

- Reset then lock: with SYNC_REQUIRED=1, drive 5 valid bits with sync=0 → locked=0, slot=0, no dout_valid. Then 16 bits 1,0,1,1,0,0,0,0,1,1,1,1,0,0,1,0 with sync on the first → dout=16'hB0F2, a single dout_valid pulse 1 cycle after the last bit, locked=1.
- Gapped stream: send the same 16 bits with din_valid deasserted for 3 cycles after slots 3 and 11 → identical dout=16'hB0F2; dout_valid occurs exactly once.
- Continuous frames: send 16'hFFFF then 16'h0001 back-to-back with sync on each slot 0 → two pulses 16 cycles apart; sync_err never asserts; slot sequence 0..15,0..15.
- Mid-frame resync: after 7 bits of a frame, assert sync with din=1, then 15 more bits all 0 → sync_err pulse 1 cycle after the sync bit; the next dout=16'h8000; the previous dout is held unchanged during the error.
- SYNC_REQUIRED=0: immediately after reset release, 16 bits of 16'h1234 with no sync → locked=1 from reset, dout=16'h1234.
- Reset mid-frame: assert rst_n=0 at slot 9 → dout=0, slot=0, dout_valid=0 with no clock edge. After release, unsynced bits are discarded until the next sync.

Source files
------------

// File: rtl/tdm_demux16.sv
// Serial-to-parallel TDM demultiplexer: one bit per valid cycle is steered into
// one of 16 lane slots; a completed frame is presented as a single 16-bit word.
module tdm_demux16 #(
    parameter bit SYNC_REQUIRED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        sync,
    output logic [0:15] dout,
    output logic        dout_valid,
    output logic [0:3]  slot,
    output logic        locked,
    output logic        sync_err
);

    localparam int unsigned LANES  = 16;
    localparam int unsigned SLOT_W = 4;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam state_t RST_STATE = SYNC_REQUIRED ? S_HUNT : S_LOCKED;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [0:LANES-2]    shadow_q, shadow_d;
    logic [0:LANES-1]    dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                sync_err_q, sync_err_d;
    logic                locked_q, locked_d;

    // Next-state: slot 15 bit is never stored; it goes straight into dout.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                S_HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                        state_d     = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (sync) begin
                        sync_err_d  = (slot_q != '0);
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                    end else if (slot_q == LAST_SLOT) begin
                        dout_d       = {shadow_q, din};
                        dout_valid_d = 1'b1;
                        slot_d       = '0;
                    end else begin
                        shadow_d[slot_q] = din;
                        slot_d           = slot_q + SLOT_W'(1);
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= (RST_STATE == S_LOCKED);
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= locked_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

endmodule
